// File: rtl/encoder_pkg.sv
// -----------------------------------------------------------------------------
// encoder_pkg
// Shared constants and types for the sequential 8-to-3 event encoder.
//   N_LINES : number of event lines (one-hot width)
//   IDX_W   : width of an encoded index
//   state_t : presentation FSM states
// -----------------------------------------------------------------------------
package encoder_pkg;

  localparam int N_LINES = 8;
  localparam int IDX_W   = 3;

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_PRESENT = 1'b1
  } state_t;

endpackage : encoder_pkg

// File: rtl/priority_encoder_8_to_3.sv
// -----------------------------------------------------------------------------
// priority_encoder_8_to_3
// Purely combinational circular priority encoder. Returns the first set bit
// of req found when scanning start, start+1, ... with natural 3-bit wrap.
// Ports:
//   req   [7:0] in  : candidate request lines
//   start [2:0] in  : index at which the search begins
//   idx   [2:0] out : selected index (only meaningful when found=1)
//   found       out : at least one request line is set
// -----------------------------------------------------------------------------
module priority_encoder_8_to_3
  import encoder_pkg::*;
(
  input  logic [N_LINES-1:0] req,
  input  logic [IDX_W-1:0]   start,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  // w_rot[j] is the request at index (start + j) mod 8, so the circular search
  // reduces to a plain lowest-set-bit search on w_rot.
  logic [N_LINES-1:0] w_rot;

  genvar gi;
  generate
    for (gi = 0; gi < N_LINES; gi++) begin : g_rot
      logic [IDX_W-1:0] w_pos;
      assign w_pos      = start + IDX_W'(gi);
      assign w_rot[gi]  = req[w_pos];
    end
  endgenerate

  logic [IDX_W-1:0] w_offset;

  always_comb begin
    w_offset = '0;
    // Scan from the top down so the lowest set offset is the last one written.
    for (int j = N_LINES - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        w_offset = IDX_W'(j);
      end
    end
  end

  assign idx   = start + w_offset;
  assign found = |req;

endmodule : priority_encoder_8_to_3

// File: rtl/event_encoder_8_to_3.sv
// -----------------------------------------------------------------------------
// event_encoder_8_to_3
// Sequential 8-to-3 encoder. Multi-hot event lines are merged into a pending
// register; pending indices are presented one at a time on out/valid and
// retired on each valid&ready handshake. Arbitration is round-robin
// (ROUND_ROBIN=1) or fixed lowest-index-first (ROUND_ROBIN=0).
// Ports:
//   clk            in  : clock, rising edge
//   rst            in  : asynchronous active-high reset
//   ena            in  : capture enable for in
//   in       [7:0] in  : event lines, bit k requests index k
//   ready          in  : consumer accepts out this cycle
//   out      [2:0] out : presented index (valid only while valid=1)
//   valid          out : out holds a pending index
//   pending  [7:0] out : pending-request register
//   overflow       out : one-cycle pulse, a request hit an unserved pending bit
// All outputs are registered.
// -----------------------------------------------------------------------------
module event_encoder_8_to_3
  import encoder_pkg::*;
#(
  parameter int ROUND_ROBIN = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic [N_LINES-1:0] in,
  input  logic               ready,
  output logic [IDX_W-1:0]   out,
  output logic               valid,
  output logic [N_LINES-1:0] pending,
  output logic               overflow
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t             r_state;
  logic [N_LINES-1:0] r_pending;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_out;
  logic               r_valid;
  logic               r_overflow;

  // ---------------------------------------------------------------------------
  // Combinational datapath
  // ---------------------------------------------------------------------------
  logic               w_transfer;
  logic [N_LINES-1:0] w_served;
  logic [N_LINES-1:0] w_avail;
  logic [N_LINES-1:0] w_capture;
  logic [IDX_W-1:0]   w_ptr_next;
  logic [IDX_W-1:0]   w_sel_idx;
  logic               w_sel_found;

  assign w_transfer = r_valid & ready;

  // One-hot of the index being retired this cycle (zero when no handshake).
  genvar gi;
  generate
    for (gi = 0; gi < N_LINES; gi++) begin : g_served
      assign w_served[gi] = w_transfer & (r_out == IDX_W'(gi));
    end
  endgenerate

  // Candidates for the next presentation exclude the index leaving now;
  // freshly captured lines only become eligible once they are registered.
  assign w_avail   = r_pending & ~w_served;
  assign w_capture = ena ? in : '0;

  // The next search starts just past the served index, so the back-to-back
  // choice already honours the rotated priority.
  assign w_ptr_next = ((ROUND_ROBIN != 0) && w_transfer) ? (r_out + IDX_W'(1)) : r_ptr;

  priority_encoder_8_to_3 u_prio (
    .req   (w_avail),
    .start (w_ptr_next),
    .idx   (w_sel_idx),
    .found (w_sel_found)
  );

  // ---------------------------------------------------------------------------
  // Registers and presentation FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pending  <= '0;
      r_ptr      <= '0;
      r_out      <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      // A line served and re-requested in the same cycle stays pending, so
      // only requests landing on a still-unserved bit count as overflow.
      r_pending  <= w_avail | w_capture;
      r_overflow <= |(w_capture & w_avail);
      r_ptr      <= w_ptr_next;

      case (r_state)
        S_IDLE: begin
          if (w_sel_found) begin
            r_out   <= w_sel_idx;
            r_valid <= 1'b1;
            r_state <= S_PRESENT;
          end
        end

        S_PRESENT: begin
          // Without a handshake out/valid hold, which keeps out stable under
          // backpressure.
          if (w_transfer) begin
            if (w_sel_found) begin
              r_out <= w_sel_idx;
            end else begin
              r_valid <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end

        default: begin
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign out      = r_out;
  assign valid    = r_valid;
  assign pending  = r_pending;
  assign overflow = r_overflow;

endmodule : event_encoder_8_to_3

// File: tb/tb_event_encoder_8_to_3.sv
module tb_event_encoder_8_to_3;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] in_v;
  logic       ready;

  logic [2:0] out_rr, out_fp;
  logic       valid_rr, valid_fp;
  logic [7:0] pend_rr, pend_fp;
  logic       ovf_rr, ovf_fp;

  int checks = 0;
  int errors = 0;
  bit log_xfer = 1'b0;

  always #5 clk = ~clk;

  event_encoder_8_to_3 #(.ROUND_ROBIN(1)) dut_rr (
    .clk(clk), .rst(rst), .ena(ena), .in(in_v), .ready(ready),
    .out(out_rr), .valid(valid_rr), .pending(pend_rr), .overflow(ovf_rr)
  );

  event_encoder_8_to_3 #(.ROUND_ROBIN(0)) dut_fp (
    .clk(clk), .rst(rst), .ena(ena), .in(in_v), .ready(ready),
    .out(out_fp), .valid(valid_fp), .pending(pend_fp), .overflow(ovf_fp)
  );

  // ---------------------------------------------------------------------------
  // Reference model: index 0 = round-robin DUT, index 1 = fixed-priority DUT
  // ---------------------------------------------------------------------------
  logic [7:0] m_pend [2];
  int         m_ptr  [2];
  logic       m_valid[2];
  int         m_out  [2];
  logic       m_ovf  [2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_pend[d] = 8'h00; m_ptr[d] = 0; m_valid[d] = 1'b0; m_out[d] = 0; m_ovf[d] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      int s;
      int start;
      int pick;
      logic [7:0] avail;
      logic [7:0] cap;
      s = (m_valid[d] && ready) ? m_out[d] : -1;
      avail = m_pend[d];
      if (s >= 0) avail[s] = 1'b0;
      cap = ena ? in_v : 8'h00;
      start = (s >= 0 && d == 0) ? (s + 1) % 8 : m_ptr[d];
      pick = -1;
      for (int k = 0; k < 8; k++)
        if (pick < 0 && avail[(start + k) % 8]) pick = (start + k) % 8;
      if (log_xfer && s >= 0)
        $display("[%0t] %s transfer idx=%0d", $time, (d == 0) ? "rr" : "fp", s);
      m_ovf[d]  = (cap & avail) != 8'h00;
      m_pend[d] = avail | cap;
      m_ptr[d]  = start;
      if (!m_valid[d]) begin
        if (pick >= 0) begin m_valid[d] = 1'b1; m_out[d] = pick; end
      end else if (s >= 0) begin
        if (pick >= 0) m_out[d] = pick;
        else m_valid[d] = 1'b0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_models();
    chk("model.rr.valid", {31'd0, valid_rr}, {31'd0, m_valid[0]});
    chk("model.rr.pending", {24'd0, pend_rr}, {24'd0, m_pend[0]});
    chk("model.rr.overflow", {31'd0, ovf_rr}, {31'd0, m_ovf[0]});
    if (m_valid[0]) chk("model.rr.out", {29'd0, out_rr}, m_out[0]);
    chk("model.fp.valid", {31'd0, valid_fp}, {31'd0, m_valid[1]});
    chk("model.fp.pending", {24'd0, pend_fp}, {24'd0, m_pend[1]});
    chk("model.fp.overflow", {31'd0, ovf_fp}, {31'd0, m_ovf[1]});
    if (m_valid[1]) chk("model.fp.out", {29'd0, out_fp}, m_out[1]);
  endtask

  task automatic drive(input logic r, input logic e, input logic [7:0] i, input logic rdy);
    @(negedge clk);
    rst = r; ena = e; in_v = i; ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
    check_models();
  endtask

  typedef struct {
    logic       rst;
    logic       ena;
    logic [7:0] in;
    logic       ready;
    logic       e_valid;
    logic [2:0] e_out;
    logic [7:0] e_pend;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[14];

  initial begin
    // Single event, reset, round-robin drain 0,3,7, then 0,3 with ptr back at 0.
    vecs[0]  = '{1'b0, 1'b1, 8'h20, 1'b1, 1'b0, 3'd0, 8'h20, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 3'd5, 8'h20, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 8'h89, 1'b1, 1'b0, 3'd0, 8'h89, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 3'd0, 8'h89, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 3'd3, 8'h88, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 3'd7, 8'h80, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 8'h09, 1'b1, 1'b0, 3'd0, 8'h09, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 3'd0, 8'h09, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 3'd3, 8'h08, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0};

    rst = 1'b1; ena = 1'b0; in_v = 8'h00; ready = 1'b0;
    model_reset();
    tick();
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    chk("reset.out", {29'd0, out_rr}, 32'd0);
    chk("reset.valid", {31'd0, valid_rr}, 32'd0);
    chk("reset.pending", {24'd0, pend_rr}, 32'd0);
    chk("reset.overflow", {31'd0, ovf_rr}, 32'd0);

    // ---- table-driven vectors on the round-robin instance -----------------
    for (int v = 0; v < 14; v++) begin
      drive(vecs[v].rst, vecs[v].ena, vecs[v].in, vecs[v].ready);
      tick();
      $display("vec %0d: in=%02h ready=%0b -> valid=%0b out=%0d pending=%02h overflow=%0b",
               v, vecs[v].in, vecs[v].ready, valid_rr, out_rr, pend_rr, ovf_rr);
      chk($sformatf("vec%0d.valid", v), {31'd0, valid_rr}, {31'd0, vecs[v].e_valid});
      chk($sformatf("vec%0d.pending", v), {24'd0, pend_rr}, {24'd0, vecs[v].e_pend});
      chk($sformatf("vec%0d.overflow", v), {31'd0, ovf_rr}, {31'd0, vecs[v].e_ovf});
      if (vecs[v].e_valid || vecs[v].rst)
        chk($sformatf("vec%0d.out", v), {29'd0, out_rr}, {29'd0, vecs[v].e_out});
    end

    // ---- asynchronous reset mid-stream with pending=FF ----------------------
    drive(1'b0, 1'b1, 8'hFF, 1'b0);
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    chk("async.pre_valid", {31'd0, valid_rr}, 32'd1);
    chk("async.pre_pending", {24'd0, pend_rr}, 32'hFF);
    #2;
    rst = 1'b1;
    #1;
    $display("async reset: valid=%0b out=%0d pending=%02h overflow=%0b", valid_rr, out_rr, pend_rr, ovf_rr);
    chk("async.out", {29'd0, out_rr}, 32'd0);
    chk("async.valid", {31'd0, valid_rr}, 32'd0);
    chk("async.pending", {24'd0, pend_rr}, 32'd0);
    chk("async.overflow", {31'd0, ovf_rr}, 32'd0);
    chk("async.fp_pending", {24'd0, pend_fp}, 32'd0);
    model_reset();
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      tick();
      chk("async.idle_valid", {31'd0, valid_rr}, 32'd0);
    end

    // ---- backpressure with overflow during the stall -----------------------
    drive(1'b1, 1'b0, 8'h00, 1'b0); tick();
    drive(1'b0, 1'b1, 8'h04, 1'b0); tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0); tick();
    chk("bp.valid", {31'd0, valid_rr}, 32'd1);
    chk("bp.out", {29'd0, out_rr}, 32'd2);
    for (int k = 0; k < 5; k++) begin
      if (k == 0) drive(1'b0, 1'b1, 8'h04, 1'b0);
      else drive(1'b0, 1'b0, 8'h00, 1'b0);
      tick();
      $display("stall %0d: valid=%0b out=%0d overflow=%0b pending=%02h", k, valid_rr, out_rr, ovf_rr, pend_rr);
      chk("bp.stall_out", {29'd0, out_rr}, 32'd2);
      chk("bp.stall_valid", {31'd0, valid_rr}, 32'd1);
      chk("bp.overflow", {31'd0, ovf_rr}, (k == 0) ? 32'd1 : 32'd0);
      chk("bp.pending2", {31'd0, pend_rr[2]}, 32'd1);
    end
    drive(1'b0, 1'b0, 8'h00, 1'b1); tick();
    chk("bp.release_valid", {31'd0, valid_rr}, 32'd0);
    chk("bp.release_pending", {24'd0, pend_rr}, 32'd0);

    // ---- serve and recapture in the same cycle -----------------------------
    drive(1'b1, 1'b0, 8'h00, 1'b0); tick();
    drive(1'b0, 1'b1, 8'h10, 1'b0); tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0); tick();
    chk("recap.out", {29'd0, out_rr}, 32'd4);
    drive(1'b0, 1'b1, 8'h10, 1'b1); tick();
    chk("recap.overflow", {31'd0, ovf_rr}, 32'd0);
    chk("recap.pending4", {31'd0, pend_rr[4]}, 32'd1);
    drive(1'b0, 1'b0, 8'h00, 1'b1); tick();
    chk("recap.again_valid", {31'd0, valid_rr}, 32'd1);
    chk("recap.again_out", {29'd0, out_rr}, 32'd4);
    drive(1'b0, 1'b0, 8'h00, 1'b1); tick();
    chk("recap.done_valid", {31'd0, valid_rr}, 32'd0);

    // ---- fixed priority vs round-robin: pointer left at 6 on the rr instance
    drive(1'b1, 1'b0, 8'h00, 1'b0); tick();
    drive(1'b0, 1'b1, 8'h20, 1'b1); tick();
    drive(1'b0, 1'b0, 8'h00, 1'b1); tick();
    drive(1'b0, 1'b0, 8'h00, 1'b1); tick();
    drive(1'b0, 1'b1, 8'h82, 1'b0); tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0); tick();
    chk("prio.rr_first", {29'd0, out_rr}, 32'd7);
    chk("prio.fp_first", {29'd0, out_fp}, 32'd1);
    // fp: re-request bit 1 while it is served; 7 is taken because bit 1 is
    // masked from the back-to-back search, then bit 1 comes back.
    drive(1'b0, 1'b1, 8'h02, 1'b1); tick();
    chk("prio.fp_second", {29'd0, out_fp}, 32'd7);
    chk("prio.rr_second", {29'd0, out_rr}, 32'd1);
    drive(1'b0, 1'b0, 8'h00, 1'b1); tick();
    chk("prio.fp_third", {29'd0, out_fp}, 32'd1);
    chk("prio.fp_pending", {24'd0, pend_fp}, 32'h02);

    // ---- randomized run against the model ---------------------------------
    log_xfer = 1'b1;
    for (int c = 0; c < 500; c++) begin
      logic r;
      r = ($urandom_range(0, 63) == 0);
      drive(r, 1'($urandom_range(0, 1)), 8'($urandom & $urandom), 1'($urandom_range(0, 3) != 0));
      tick();
    end
    log_xfer = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_event_encoder_8_to_3
